// File: rtl/move_scheduler_if.sv
// Grant handshake and configuration bus for move_scheduler.
//   cfg_we/cfg_idx/cfg_rate : rate programming from game control
//   enable                  : allow new grant offers
//   grant_valid/grant_id    : offered move grant (scheduler -> datapath)
//   grant_ack               : datapath accepts the offered grant
//   pending/missed          : per-slot status flags
interface move_scheduler_if #(
  parameter int N = 4
);
  logic         cfg_we;
  logic [1:0]   cfg_idx;
  logic [7:0]   cfg_rate;
  logic         enable;
  logic         grant_valid;
  logic [1:0]   grant_id;
  logic         grant_ack;
  logic [N-1:0] pending;
  logic [N-1:0] missed;

  // Scheduler side
  modport master (
    input  cfg_we, cfg_idx, cfg_rate, enable, grant_ack,
    output grant_valid, grant_id, pending, missed
  );

  // Control / datapath side
  modport slave (
    output cfg_we, cfg_idx, cfg_rate, enable, grant_ack,
    input  grant_valid, grant_id, pending, missed
  );
endinterface

// File: rtl/move_scheduler.sv
// move_scheduler: shared tick prescaler, one fractional phase accumulator per
// mover slot, and a round-robin valid/ack arbiter handing move events one at a
// time to the position-update datapath.
// Ports:
//   clock  : system clock, rising edge
//   resetn : asynchronous active-low reset
//   bus    : move_scheduler_if master modport (config, enable, grant handshake,
//            pending/missed status)
module move_scheduler #(
  parameter int CLK_HZ  = 50000000,
  parameter int TICK_HZ = 1000,
  parameter int N       = 4
) (
  input  logic             clock,
  input  logic             resetn,
  move_scheduler_if.master bus
);

  localparam int            DIV      = CLK_HZ / TICK_HZ;
  localparam int            PW       = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
  localparam logic [16:0]   TICK17   = 17'(TICK_HZ);
  localparam logic [1:0]    LAST_RST = 2'(N - 1);

  typedef enum logic {IDLE, OFFER} state_t;

  state_t        state_q;
  logic [PW-1:0] pres_q;
  logic          tick;
  logic [7:0]    rate_q  [N];
  logic [15:0]   acc_q   [N];
  logic [15:0]   acc_nxt [N];
  logic [N-1:0]  ev;
  logic [N-1:0]  pending_q;
  logic [N-1:0]  missed_q;
  logic          gv_q;
  logic [1:0]    gid_q;
  logic [1:0]    last_q;
  logic [16:0]   sum;
  logic [1:0]    cand;
  logic          sel_found;
  logic [1:0]    sel_id;

  assign tick = (pres_q == PRE_LAST);

  // Accumulate on tick; an event fires when the phase crosses TICK_HZ, and the
  // remainder is carried so the long-run rate has no drift.
  always_comb begin
    sum = '0;
    for (int unsigned i = 0; i < N; i++) begin
      ev[i]      = 1'b0;
      acc_nxt[i] = acc_q[i];
      sum        = {1'b0, acc_q[i]} + {9'b0, rate_q[i]};
      if (tick && (rate_q[i] != '0)) begin
        if ({9'b0, rate_q[i]} >= TICK17) begin
          ev[i]      = 1'b1;
          acc_nxt[i] = '0;
        end else if (sum >= TICK17) begin
          ev[i]      = 1'b1;
          acc_nxt[i] = 16'(sum - TICK17);
        end else begin
          acc_nxt[i] = sum[15:0];
        end
      end
    end
  end

  // Round-robin pick: first pending slot searching upward from last+1.
  always_comb begin
    cand      = '0;
    sel_found = 1'b0;
    sel_id    = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand = 2'((32'(last_q) + k) % N);
      if (!sel_found && pending_q[cand]) begin
        sel_found = 1'b1;
        sel_id    = cand;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      pres_q    <= '0;
      pending_q <= '0;
      missed_q  <= '0;
      gv_q      <= 1'b0;
      gid_q     <= '0;
      last_q    <= LAST_RST;
      for (int unsigned i = 0; i < N; i++) begin
        rate_q[i] <= '0;
        acc_q[i]  <= '0;
      end
    end else begin
      pres_q <= tick ? '0 : pres_q + PW'(1);

      for (int unsigned i = 0; i < N; i++) begin
        // A same-cycle event re-arms pending instead of counting as a miss.
        if (ev[i]) begin
          pending_q[i] <= 1'b1;
          if (pending_q[i] && !((state_q == OFFER) && bus.grant_ack && (gid_q == 2'(i))))
            missed_q[i] <= 1'b1;
        end else if ((state_q == OFFER) && bus.grant_ack && (gid_q == 2'(i))) begin
          pending_q[i] <= 1'b0;
        end

        // Config write overrides the accumulate and clears the miss flag.
        if (bus.cfg_we && (bus.cfg_idx == 2'(i))) begin
          rate_q[i]   <= bus.cfg_rate;
          acc_q[i]    <= '0;
          missed_q[i] <= 1'b0;
        end else begin
          acc_q[i]    <= acc_nxt[i];
        end
      end

      case (state_q)
        IDLE: begin
          if (bus.enable && sel_found) begin
            gid_q   <= sel_id;
            gv_q    <= 1'b1;
            state_q <= OFFER;
          end
        end
        OFFER: begin
          if (bus.grant_ack) begin
            gv_q    <= 1'b0;
            last_q  <= gid_q;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.grant_valid = gv_q;
  assign bus.grant_id    = gid_q;
  assign bus.pending     = pending_q;
  assign bus.missed      = missed_q;

endmodule
